// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receiver: register map, STATUS layout, FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package uart_rx_ctrl_pkg;

  // Word addresses (bridge addr[3:2]); 3 is reserved.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;

  // STATUS bit positions.
  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_PERR    = 4;
  localparam int ST_CNT_LSB = 5;

  // Receiver FSM. RX_PARITY is only reachable in the 8E1 build.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // STATUS byte, MSB first so the field order matches the ST_* positions.
  typedef struct packed {
    logic [2:0] count;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       full;
    logic       nempty;
  } status_t;

  // FIFO occupancy saturated to the 3-bit STATUS field.
  function automatic logic [2:0] clip_count(input logic [4:0] cnt);
    return (cnt > 5'd7) ? 3'd7 : cnt[2:0];
  endfunction

  // Divisors below 2 would make the half-bit wait zero; floor them at 2.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: synchronous push/pop with occupancy count and full/empty flags.
// Latency: a push is visible at head/count on the edge it is accepted; pop advances head on its edge.
// Backpressure: push on full is dropped unless a pop happens on the same edge; pop on empty is ignored.
//
// Ports: clk, reset (sync, active-high); push_vld/push_dat write side;
//        pop_rdy read side; head_dat, count, full, empty status.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_vld && (!full || pop_rdy);
  assign pop_ok   = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Memory-mapped UART receiver: 8N1 (8E1 with UART_RX_PARITY_EN) deframer, byte FIFO, CPU registers, irq.
// Latency: byte reaches the FIFO (irq high) one edge after the stop-bit sample; rdata is combinational.
// Backpressure: none on the serial side; a byte arriving at a full FIFO is dropped and OVR is set.
//
// Ports: clk, reset (sync, active-high); uart_rxd async serial in (idle high);
//        addr/rd_en/wr_en/wdata/rdata word register bus (0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved);
//        irq high while the FIFO holds data.
// Build option: define UART_RX_PARITY_EN for an even-parity bit between bit 7 and the stop bit.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DIV_RESET  = 2604,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Synchronizer
  logic rx_meta;
  logic rx_s;

  // Deframer
  rx_state_t   state;
  logic [15:0] div;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        push_vld;
  logic [7:0]  push_dat;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
`endif

  // Sticky error flags
  logic ovr;
  logic ferr;
  logic perr;

  // FIFO side
  logic [7:0]       head_dat;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;

  // Bus decode
  logic    pop;
  logic    status_wr;
  logic    div_wr;
  logic    ovr_set;
  status_t status;

  assign pop       = rd_en && (addr == ADDR_DATA) && !fifo_empty;
  assign status_wr = wr_en && (addr == ADDR_STATUS);
  assign div_wr    = wr_en && (addr == ADDR_DIVISOR);
  // A pop on the push edge makes room, so only a push with no room overflows.
  assign ovr_set   = push_vld && fifo_full && !pop;

  // Two-flop synchronizer, reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_s    <= rx_meta;
    end
  end

  // The FSM only reads div when it reloads bit_cnt, so a write never disturbs a bit in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= 16'(DIV_RESET);
    end else if (div_wr) begin
      div <= clamp_div(wdata[15:0]);
    end
  end

  // Deframer FSM plus sticky flags. Clears are written first so a set on the same edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr     <= 1'b0;
      par_bad  <= 1'b0;
`endif
    end else begin
      push_vld <= 1'b0;

      if (status_wr && wdata[ST_OVR])  ovr  <= 1'b0;
      if (status_wr && wdata[ST_FERR]) ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (status_wr && wdata[ST_PERR]) perr <= 1'b0;
`endif
      if (ovr_set) ovr <= 1'b1;

      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            // Half a bit lands the start-bit check at its centre.
            bit_cnt <= div >> 1;
            state   <= RX_START;
          end
        end

        RX_START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 16'd1;
          end else if (!rx_s) begin
            bit_cnt <= div - 16'd1;
            bit_idx <= '0;
            state   <= RX_DATA;
          end else begin
            // Line went back high before mid-bit: a glitch, not a frame.
            state <= RX_IDLE;
          end
        end

        RX_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 16'd1;
          end else begin
            shreg[bit_idx] <= rx_s;
            bit_cnt        <= div - 16'd1;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 16'd1;
          end else begin
            // Even parity: the parity bit equals the XOR of the data bits.
            par_bad <= (rx_s != ^shreg);
            if (rx_s != ^shreg) perr <= 1'b1;
            bit_cnt <= div - 16'd1;
            state   <= RX_STOP;
          end
        end
`endif

        RX_STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 16'd1;
          end else begin
            state <= RX_IDLE;
            if (!rx_s) begin
              ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!par_bad) begin
`else
            end else begin
`endif
              push_vld <= 1'b1;
              push_dat <= shreg;
            end
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .head_dat (head_dat),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign irq = !fifo_empty;

  always_comb begin
    status        = '0;
    status.nempty = !fifo_empty;
    status.full   = fifo_full;
    status.ovr    = ovr;
    status.ferr   = ferr;
    status.perr   = perr;
    status.count  = clip_count(5'(fifo_cnt));
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:    if (!fifo_empty) rdata[7:0] = head_dat;
      ADDR_STATUS:  rdata[7:0]  = status;
      ADDR_DIVISOR: rdata[15:0] = div;
      default:      rdata = '0;
    endcase
  end

  // Write-data bits with no register behind them.
  logic unused_wdata;
`ifdef UART_RX_PARITY_EN
  assign unused_wdata = ^wdata[31:16];
`else
  assign unused_wdata = ^{wdata[31:16], wdata[ST_PERR]};
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        uart_rxd;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int tests;
  int failed;
  int tb_div;

  uart_rx_ctrl #(
    .DIV_RESET  (2604),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at posedge+1.
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr  = a;
    rd_en = 1'b1;
    #1 d  = rdata;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (tb_div) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop);
    uart_rxd = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  logic [31:0] d;
  int          lat;
  int          lat_lo;
  int          lat_hi;
  int          n;

  initial begin
    tests    = 0;
    failed   = 0;
    tb_div   = 16;
    uart_rxd = 1'b1;
    addr     = 2'd0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    wdata    = '0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_irq", {31'b0, irq}, 32'd0);
    bus_read(ADDR_DATA, d);    check("rst_data", d, 32'd0);
    bus_read(ADDR_STATUS, d);  check("rst_status", d, 32'd0);
    bus_read(ADDR_DIVISOR, d); check("rst_div", d, 32'd2604);

    // Divisor clamp, reserved address, then div = 16
    bus_write(ADDR_DIVISOR, 32'd1);
    bus_read(ADDR_DIVISOR, d); check("div_clamp", d, 32'd2);
    bus_write(ADDR_DIVISOR, 32'h0001_0010);
    bus_read(ADDR_DIVISOR, d); check("div_16", d, 32'd16);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);         check("rsvd_read", d, 32'd0);
    bus_read(ADDR_DIVISOR, d); check("rsvd_wr_noeffect", d, 32'd16);

    // 0x55: latency, data, pop
`ifdef UART_RX_PARITY_EN
    lat_lo = 166; lat_hi = 178;
`else
    lat_lo = 150; lat_hi = 162;
`endif
    lat = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        while (!irq && lat < 400) begin
          @(posedge clk);
          #1 lat++;
        end
      end
    join
    check("lat_window", {31'b0, (lat >= lat_lo && lat <= lat_hi)}, 32'd1);
    bus_read(ADDR_STATUS, d);  check("x55_status", d, 32'h21);
    bus_read(ADDR_DATA, d);    check("x55_data", d, 32'h55);
    check("x55_irq_after", {31'b0, irq}, 32'd0);
    bus_read(ADDR_STATUS, d);  check("x55_status_after", d, 32'h00);

    // Four-cycle glitch on the line
    uart_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_idle", 32'(dut.state), 32'(RX_IDLE));
    check("glitch_irq", {31'b0, irq}, 32'd0);
    bus_read(ADDR_STATUS, d);  check("glitch_status", d, 32'h00);

    // Framing error
    send_byte(8'hA3, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    bus_read(ADDR_STATUS, d);  check("ferr_status", d, 32'h08);
    bus_write(ADDR_STATUS, 32'h8);
    bus_read(ADDR_STATUS, d);  check("ferr_clear", d, 32'h00);

    // Overflow: five bytes into four slots
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    bus_read(ADDR_STATUS, d);  check("ovr_status", d, 32'h87);
    check("ovr_irq", {31'b0, irq}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      bus_read(ADDR_DATA, d);  check($sformatf("ovr_data%0d", i), d, 32'(i));
    end
    bus_read(ADDR_DATA, d);    check("empty_read", d, 32'd0);
    bus_read(ADDR_STATUS, d);  check("ovr_sticky", d, 32'h04);
    bus_write(ADDR_STATUS, 32'h4);
    bus_read(ADDR_STATUS, d);  check("ovr_clear", d, 32'h00);

    // Pop on the same edge as a push into a full FIFO
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
    bus_read(ADDR_STATUS, d);  check("full_status", d, 32'h83);
    fork
      send_byte(8'h15, 1'b1);
      begin
        n = 0;
        while (!dut.push_vld && n < 400) begin
          @(posedge clk);
          #1 n++;
        end
        check("push_seen", {31'b0, dut.push_vld}, 32'd1);
        bus_read(ADDR_DATA, d);
        check("popush_data", d, 32'h11);
      end
    join
    bus_read(ADDR_STATUS, d);  check("popush_status", d, 32'h83);
    for (int i = 0; i < 4; i++) begin
      bus_read(ADDR_DATA, d);  check($sformatf("popush_data%0d", i), d, 32'h12 + 32'(i));
    end
    bus_read(ADDR_STATUS, d);  check("popush_drained", d, 32'h00);

    // Reset mid-frame (after bit 3), with a byte already buffered
    send_byte(8'h33, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    uart_rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_irq", {31'b0, irq}, 32'd0);
    bus_read(ADDR_STATUS, d);  check("midrst_status", d, 32'h00);
    bus_read(ADDR_DIVISOR, d); check("midrst_div", d, 32'd2604);
    bus_write(ADDR_DIVISOR, 32'd16);
    send_byte(8'h7E, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus_read(ADDR_DATA, d);    check("post_rst_data", d, 32'h7E);
    bus_read(ADDR_STATUS, d);  check("post_rst_status", d, 32'h00);

`ifdef UART_RX_PARITY_EN
    send_par(8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus_read(ADDR_DATA, d);    check("par_ok_data", d, 32'h0F);
    send_par(8'h0F, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus_read(ADDR_STATUS, d);  check("par_bad_status", d, 32'h10);
    bus_write(ADDR_STATUS, 32'h10);
    bus_read(ADDR_STATUS, d);  check("perr_clear", d, 32'h00);
`else
    bus_write(ADDR_STATUS, 32'h1C);
    bus_read(ADDR_STATUS, d);  check("perr_w1c_nop", d, 32'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Memory-mapped UART receiver peripheral for the P8 CPU bridge: samples the board `uart_rxd` line (8N1), assembles bytes, buffers them in a 4-entry FIFO and exposes them to the CPU as three word registers plus a level interrupt. It is the receiving end of the serial link whose transmit side the CPU drives, and sits beside the timer and LED/tube devices behind the system bridge.

## Interface
- `DIV_RESET`, 2604: reset value of the baud divisor (clk cycles per bit; 25 MHz / 9600).
- `FIFO_DEPTH`, 4: receive FIFO entries (power of two, 2..16).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rxd`  in  1  asynchronous serial input, idle high.
- `addr`  in  2  word address (bridge `addr[3:2]`): 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved.
- `rd_en`  in  1  read strobe, one cycle.
- `wr_en`  in  1  write strobe, one cycle.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr` and state.
- `irq`  out  1  high while FIFO non-empty.

## Operation
- Input passes a 2-flop synchronizer (initialized to 1); FSM sees `rx_s`.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: on `rx_s`==0 load bit counter with `div>>1`, go START.
  - START: at counter zero, `rx_s`==0 -> load `div-1`, bit index 0, go DATA; `rx_s`==1 -> glitch, back to IDLE, nothing recorded.
  - DATA: at each counter zero sample into bit `idx` (LSB first), reload `div-1`; after bit 7 go STOP (or PARITY).
  - STOP: at counter zero, `rx_s`==1 -> push byte; `rx_s`==0 -> set FERR, drop byte. Return to IDLE same edge.
- Push to full FIFO: byte dropped, OVR set, FIFO contents untouched.
- Registers:
  - DATA (read): `{24'b0, head byte}`; read with FIFO non-empty pops at that edge; empty read returns 0, no pop. Writes ignored.
  - STATUS (read): bit0 non-empty, bit1 full, bit2 OVR, bit3 FERR, bit4 PERR, bits 7:5 count clipped, rest 0. Write: bits 2-4 write-1-to-clear.
  - DIVISOR (rw): bits 15:0; write takes effect at next reload, never mid-count; values <2 are stored as 2.
- Simultaneous push and pop: both performed, count unchanged. Pop on full with push: both succeed, no OVR. Error set and W1C on same edge: set wins.

## Timing
- Reset values: FSM IDLE, counters 0, FIFO empty, flags 0, `div`=`DIV_RESET`, synchronizer 1; hence `rdata`=0 for DATA, `irq`=0.
- Latency: byte visible (`irq` high) on the edge following the stop-bit sample, i.e. ~2 + 9.5·div cycles after the start-bit falling edge (10.5·div with parity).
- Sample point is bit centre ±1 cycle; tolerates ±4% baud mismatch.
- `reset` mid-frame aborts the frame immediately, flushes FIFO; a line still low after reset is treated as a new start bit.
- `rd_en`/`wr_en` to reserved address: no effect, `rdata`=0.

## Configuration
- `UART_RX_PARITY_EN`: defined -> 8E1 frame, PARITY state samples an even-parity bit after bit 7; mismatch sets PERR and drops the byte, stop bit still checked. Undefined -> 8N1, no PARITY state, PERR reads 0 and W1C is ignored.

## Structure
- Shared package: register address constants (DATA/STATUS/DIVISOR), STATUS bit positions, FSM state encoding.
- One sub-module `uart_rx_fifo` (synchronous push/pop, count, full/empty); FSM, synchronizer and register decode stay in the top.

## Test plan
- `div`=16, send 0x55 8N1 -> `irq` rises after ~154 cycles, DATA read = 0x55, next cycle `irq`=0, count 0.
- Low pulse of 4 cycles on `uart_rxd` -> FSM back in IDLE, no byte, STATUS = 0.
- 0xA3 with stop bit 0 -> FERR set, FIFO empty; write STATUS 0x8 -> FERR cleared.
- 5 bytes 0x01..0x05 without reads -> STATUS full, OVR=1; reads return 0x01..0x04, then empty read 0.
- Pop on same edge as push into full FIFO -> count stays 4, OVR=0; reset asserted mid-frame (after bit 3) -> FIFO empty, `irq` 0, next clean frame 0x7E received correctly.
- With `UART_RX_PARITY_EN`: 0x0F + parity 0 accepted; 0x0F + parity 1 -> PERR=1, nothing pushed.
